// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constant helpers for the floating-point datapath.
package fp_pkg;

  // Operand classification after denormals-are-zero flushing
  typedef enum logic [1:0] {
    FP_ZERO = 2'b00,
    FP_NORM = 2'b01,
    FP_INF  = 2'b10,
    FP_NAN  = 2'b11
  } fp_class_t;

  // Rounding modes, encoded as on the rnd_mode port
  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_t;

  // Widest word the constant builders can produce; callers cast down
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round / range-check / special-case
// pack of a raw significand product. Written to be shareable with an adder.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                        sign,
  input  fp_class_t                   cls_a,
  input  fp_class_t                   cls_b,
  input  logic signed [EXP_W+1:0]     exp_sum,
  input  logic [2*MAN_W+1:0]          prod,
  input  rnd_mode_t                   rnd_mode,
  output logic [EXP_W+MAN_W:0]        result,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        invalid,
  output logic                        inexact
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX    = EXP_W'(fp_emax(EXP_W));
  localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - 1'b1;
  localparam logic signed [EXP_W+1:0] EMAX_X = $signed({2'b00, EMAX});
  localparam logic [EXP_W+MAN_W:0] QNAN = (EXP_W+MAN_W+1)'(fp_qnan(EXP_W, MAN_W));

  logic [MAN_W-1:0]        mant;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic                    max_finite;
  logic                    carry;
  logic [MAN_W:0]          mant_rnd;
  logic signed [EXP_W+1:0] exp_norm;
  logic signed [EXP_W+1:0] exp_fin;
  logic                    any_nan;
  logic                    any_inf;
  logic                    any_zero;
  logic                    inf_times_zero;

  // Pick the mantissa window: product of two [1,2) significands lies in [1,4)
  always_comb begin
    if (prod[PW-1]) begin
      mant   = prod[PW-2 -: MAN_W];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
    end else begin
      mant   = prod[PW-3 -: MAN_W];
      guard  = prod[MAN_W-1];
      sticky = |prod[MAN_W-2:0];
    end
  end

  // Rounding increment and whether an overflow saturates to max finite
  always_comb begin
    inc        = 1'b0;
    max_finite = 1'b0;
    unique case (rnd_mode)
      RND_RNE: inc = guard & (sticky | mant[0]);
      RND_RTZ: max_finite = 1'b1;
      RND_RUP: begin
        inc        = (guard | sticky) & ~sign;
        max_finite = sign;
      end
      RND_RDN: begin
        inc        = (guard | sticky) & sign;
        max_finite = ~sign;
      end
      default: inc = 1'b0;
    endcase
  end

  assign mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  assign carry    = mant_rnd[MAN_W];
  assign exp_norm = exp_sum + {{(EXP_W+1){1'b0}}, prod[PW-1]};
  assign exp_fin  = exp_norm + {{(EXP_W+1){1'b0}}, carry};

  assign any_nan        = (cls_a == FP_NAN) || (cls_b == FP_NAN);
  assign any_inf        = (cls_a == FP_INF) || (cls_b == FP_INF);
  assign any_zero       = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);
  assign inf_times_zero = any_inf && any_zero;

  // Final pack: specials first (no rounding flags), then overflow, FTZ, finite
  always_comb begin
    result    = {sign, exp_fin[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    invalid   = 1'b0;
    inexact   = guard | sticky;
    if (any_nan || inf_times_zero) begin
      result  = QNAN;
      invalid = 1'b1;
      inexact = 1'b0;
    end else if (any_inf) begin
      result  = {sign, EMAX, {MAN_W{1'b0}}};
      inexact = 1'b0;
    end else if (any_zero) begin
      result  = {sign, {(EXP_W+MAN_W){1'b0}}};
      inexact = 1'b0;
    end else if (exp_fin >= EMAX_X) begin
      overflow = 1'b1;
      inexact  = 1'b1;
      result   = max_finite ? {sign, EMAX_M1, {MAN_W{1'b1}}}
                            : {sign, EMAX, {MAN_W{1'b0}}};
    end else if (exp_fin[EXP_W+1] || (exp_fin == '0)) begin
      underflow = 1'b1;
      inexact   = 1'b1;
      result    = {sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier, valid/ready on
// both sides, whole pipe stalls together when the output is held.
// Define FP_MUL_ROUND_MODE_EN to add the rnd_mode port (RNE/RTZ/RUP/RDN);
// without it the unit rounds to nearest even only.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
`ifdef FP_MUL_ROUND_MODE_EN
  input  logic [1:0]           rnd_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_overflow,
  output logic                 flag_underflow,
  output logic                 flag_invalid,
  output logic                 flag_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = EXP_W'(fp_emax(EXP_W));
  localparam logic signed [EXP_W+1:0] BIAS_X = (EXP_W+2)'(fp_bias(EXP_W));

  logic                    advance;
  rnd_mode_t               rnd_in;
  logic [W-1:0]            ops       [2];
  logic [EXP_W-1:0]        exp_fld   [2];
  fp_class_t               cls_next  [2];
  logic [MAN_W:0]          sig_next  [2];
  logic signed [EXP_W+1:0] exp_sum_next;
  logic [PW-1:0]           prod_next;

  // Stage 1 registers
  logic                    s1_valid_reg;
  logic                    s1_sign_reg;
  fp_class_t               s1_cls_reg [2];
  logic signed [EXP_W+1:0] s1_exp_reg;
  logic [MAN_W:0]          s1_sig_reg [2];
  rnd_mode_t               s1_rnd_reg;

  // Stage 2 registers
  logic                    s2_valid_reg;
  logic                    s2_sign_reg;
  fp_class_t               s2_cls_reg [2];
  logic signed [EXP_W+1:0] s2_exp_reg;
  logic [PW-1:0]           s2_prod_reg;
  rnd_mode_t               s2_rnd_reg;

  // Stage 3 (output) registers
  logic                    out_valid_reg;
  logic [W-1:0]            result_reg;
  logic                    ovf_reg, unf_reg, inv_reg, inx_reg;
  logic [W-1:0]            result_next;
  logic                    ovf_next, unf_next, inv_next, inx_next;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;

`ifdef FP_MUL_ROUND_MODE_EN
  assign rnd_in = rnd_mode_t'(rnd_mode);
`else
  assign rnd_in = RND_RNE;
`endif

  assign ops[0] = a;
  assign ops[1] = b;

  // Per-operand unpack and classify; subnormal inputs are treated as zero
  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign exp_fld[gi]  = ops[gi][W-2 -: EXP_W];
    assign sig_next[gi] = {1'b1, ops[gi][MAN_W-1:0]};
    assign cls_next[gi] = (exp_fld[gi] == '0)   ? FP_ZERO :
                          (exp_fld[gi] != EMAX) ? FP_NORM :
                          (ops[gi][MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
  end

  assign exp_sum_next = $signed({2'b00, exp_fld[0]}) + $signed({2'b00, exp_fld[1]}) - BIAS_X;
  assign prod_next    = PW'(s1_sig_reg[0]) * PW'(s1_sig_reg[1]);

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign      (s2_sign_reg),
    .cls_a     (s2_cls_reg[0]),
    .cls_b     (s2_cls_reg[1]),
    .exp_sum   (s2_exp_reg),
    .prod      (s2_prod_reg),
    .rnd_mode  (s2_rnd_reg),
    .result    (result_next),
    .overflow  (ovf_next),
    .underflow (unf_next),
    .invalid   (inv_next),
    .inexact   (inx_next)
  );

  // Pipeline registers: every stage moves together when advance is high
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_exp_reg    <= '0;
      s1_rnd_reg    <= RND_RNE;
      s2_valid_reg  <= 1'b0;
      s2_sign_reg   <= 1'b0;
      s2_exp_reg    <= '0;
      s2_prod_reg   <= '0;
      s2_rnd_reg    <= RND_RNE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      inv_reg       <= 1'b0;
      inx_reg       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_cls_reg[i] <= FP_ZERO;
        s1_sig_reg[i] <= '0;
        s2_cls_reg[i] <= FP_ZERO;
      end
    end else if (advance) begin
      s1_valid_reg  <= in_valid;
      s1_sign_reg   <= a[W-1] ^ b[W-1];
      s1_exp_reg    <= exp_sum_next;
      s1_rnd_reg    <= rnd_in;
      s2_valid_reg  <= s1_valid_reg;
      s2_sign_reg   <= s1_sign_reg;
      s2_exp_reg    <= s1_exp_reg;
      s2_prod_reg   <= prod_next;
      s2_rnd_reg    <= s1_rnd_reg;
      out_valid_reg <= s2_valid_reg;
      result_reg    <= result_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      inv_reg       <= inv_next;
      inx_reg       <= inx_next;
      for (int i = 0; i < 2; i++) begin
        s1_cls_reg[i] <= cls_next[i];
        s1_sig_reg[i] <= sig_next[i];
        s2_cls_reg[i] <= s1_cls_reg[i];
      end
    end
  end

  assign out_valid      = out_valid_reg;
  assign result         = result_reg;
  assign flag_overflow  = ovf_reg;
  assign flag_underflow = unf_reg;
  assign flag_invalid   = inv_reg;
  assign flag_inexact   = inx_reg;

endmodule
